axis_decimator: RTL and testbench

- Integer nearest-neighbour downscaler, placed directly downstream of axis_window on the video AXI4-Stream path.
- Keeps every h_step-th pixel of every v_step-th line of the cropped window.
- Regenerates tuser (start of frame) and tlast (end of line) for the reduced image.
- Line width is never supplied: each kept pixel is held until the block knows whether it is the last kept pixel of its line.

---
 rtl/axis_decimator_pkg.sv | 21 ++
 rtl/axis_decimator_if.sv | 19 +
 rtl/axis_decimator_phase.sv | 45 ++++
 rtl/axis_decimator.sv | 102 ++++++++++
 tb/tb_axis_decimator.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/axis_decimator_pkg.sv
// axis_decimator_pkg: shared defaults, output-register actions and step normalisation
//   C_STEP_BITS_DEF   default width of the h_step/v_step inputs
//   C_PIXEL_WIDTH_DEF default tdata width
//   o_op_e            what the output register does on a given cycle
//   norm_step()       maps a programmed step of 0 onto 1
package axis_decimator_pkg;

    localparam int C_STEP_BITS_DEF   = 4;
    localparam int C_PIXEL_WIDTH_DEF = 8;

    // O_PUSH: held pixel moves to O mid-line
    // O_LAST: held pixel moves to O as end of line, triggered by a dropped tlast pixel
    // O_FLUSH: held pixel moves to O as end of line while the input is stalled
    typedef enum logic [1:0] {O_IDLE, O_PUSH, O_LAST, O_FLUSH} o_op_e;

    // A step of zero means "keep every pixel".
    function automatic logic [15:0] norm_step(input logic [15:0] s);
        return (s == 16'd0) ? 16'd1 : s;
    endfunction

endpackage

// File: rtl/axis_decimator_if.sv
// axis_decimator_if: video AXI4-Stream bundle
//   tdata  pixel, tuser start of frame, tlast end of line, tvalid/tready handshake
//   master drives tdata/tuser/tlast/tvalid; slave drives tready
interface axis_decimator_if
    import axis_decimator_pkg::*;
#(
    parameter int C_PIXEL_WIDTH = C_PIXEL_WIDTH_DEF
);

    logic [C_PIXEL_WIDTH-1:0] tdata;
    logic                     tuser;
    logic                     tlast;
    logic                     tvalid;
    logic                     tready;

    modport master (output tdata, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tuser, tlast, tvalid, output tready);

endinterface

// File: rtl/axis_decimator_phase.sv
// axis_decimator_phase: wrap counter with clear, advance, zero and step latch
//   clk, resetn  clock, synchronous active-low reset
//   clr          forces the phase to 0 before it is evaluated this cycle
//   ld           latches step_in (normalised) as the wrap interval
//   adv          advances the phase, wrapping at step-1
//   zero         forces the next phase to 0 (overrides adv)
//   step_in      programmed step, 0 treated as 1
//   ph           phase to evaluate this cycle (already cleared when clr=1)
module axis_decimator_phase
    import axis_decimator_pkg::*;
#(
    parameter int C_STEP_BITS = C_STEP_BITS_DEF
)(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clr,
    input  logic                   ld,
    input  logic                   adv,
    input  logic                   zero,
    input  logic [C_STEP_BITS-1:0] step_in,
    output logic [C_STEP_BITS-1:0] ph
);

    localparam logic [C_STEP_BITS-1:0] ONE = C_STEP_BITS'(1);

    logic [C_STEP_BITS-1:0] ph_q, step_q, step_eff, ph_nxt;

    // The step being latched is already in force for the pixel that latches it.
    always_comb begin
        step_eff = ld ? C_STEP_BITS'(norm_step(16'(step_in))) : step_q;
        ph       = clr ? '0 : ph_q;
        ph_nxt   = zero ? '0 : !adv ? ph : (ph == step_eff - ONE) ? '0 : ph + ONE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ph_q   <= '0;
            step_q <= ONE;
        end else begin
            ph_q   <= ph_nxt;
            step_q <= step_eff;
        end
    end

endmodule

// File: rtl/axis_decimator.sv
// axis_decimator: nearest-neighbour downscaler keeping every h_step-th pixel of every v_step-th line
//   clk, resetn     clock, synchronous active-low reset
//   h_step, v_step  keep intervals (0 treated as 1), latched on each accepted start of frame
//   s_axis          input video stream (slave)
//   m_axis          reduced video stream (master), tuser/tlast regenerated
module axis_decimator
    import axis_decimator_pkg::*;
#(
    parameter int C_PIXEL_WIDTH = C_PIXEL_WIDTH_DEF,
    parameter int C_STEP_BITS   = C_STEP_BITS_DEF
)(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [C_STEP_BITS-1:0] h_step,
    input  logic [C_STEP_BITS-1:0] v_step,
    axis_decimator_if.slave        s_axis,
    axis_decimator_if.master       m_axis
);

    logic [C_STEP_BITS-1:0]   col_ph, row_ph;
    logic [C_PIXEL_WIDTH-1:0] h_data, o_data;
    logic                     h_valid, h_user, lastpend;
    logic                     o_valid, o_user, o_last;
    logic                     o_free, flush_req, acc, sof, eol, keep;
    o_op_e                    op;

    // A kept pixel waits in H until we know whether another kept pixel follows on its line.
    // H must be drained as end of line before a new frame may start.
    assign o_free        = ~o_valid | m_axis.tready;
    assign flush_req     = lastpend | (h_valid & s_axis.tvalid & s_axis.tuser);
    assign s_axis.tready = resetn & ~flush_req & o_free;
    assign acc           = s_axis.tvalid & s_axis.tready;
    assign sof           = acc & s_axis.tuser;
    assign eol           = acc & s_axis.tlast;
    assign keep          = acc & (col_ph == '0) & (row_ph == '0);

    axis_decimator_phase #(.C_STEP_BITS(C_STEP_BITS)) u_col (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (sof),
        .ld      (sof),
        .adv     (acc),
        .zero    (eol),
        .step_in (h_step),
        .ph      (col_ph)
    );

    axis_decimator_phase #(.C_STEP_BITS(C_STEP_BITS)) u_row (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (sof),
        .ld      (sof),
        .adv     (eol),
        .zero    (1'b0),
        .step_in (v_step),
        .ph      (row_ph)
    );

    // Flush and acceptance are exclusive: a pending flush holds tready low.
    always_comb begin
        op = (flush_req & o_free)        ? O_FLUSH :
             (keep & h_valid)            ? O_PUSH  :
             (eol & ~keep & h_valid)     ? O_LAST  : O_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_user   <= 1'b0;
            o_last   <= 1'b0;
            h_valid  <= 1'b0;
            h_data   <= '0;
            h_user   <= 1'b0;
            lastpend <= 1'b0;
        end else begin
            if (op != O_IDLE) begin
                o_valid <= 1'b1;
                o_data  <= h_data;
                o_user  <= h_user;
                o_last  <= (op != O_PUSH);
            end else if (m_axis.tready) begin
                o_valid <= 1'b0;
            end
            if (keep) begin
                h_valid  <= 1'b1;
                h_data   <= s_axis.tdata;
                h_user   <= s_axis.tuser;
                lastpend <= s_axis.tlast;
            end else if (op == O_FLUSH || op == O_LAST) begin
                h_valid  <= 1'b0;
                lastpend <= 1'b0;
            end
        end
    end

    assign m_axis.tdata  = o_data;
    assign m_axis.tuser  = o_user;
    assign m_axis.tlast  = o_last;
    assign m_axis.tvalid = o_valid;

endmodule

// File: tb/tb_axis_decimator.sv
// tb_axis_decimator: table-driven frames with a scoreboard for axis_decimator
module tb_axis_decimator;

    typedef struct packed {
        logic [7:0] d;
        logic       u;
        logic       l;
    } exp_t;

    typedef struct {
        int w, h, hs, vs, hs_mid, rnd, beats, stalls;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] h_step = 4'd1;
    logic [3:0] v_step = 4'd1;
    logic       rnd_ready = 1'b0;
    int         compared = 0;
    int         failed = 0;
    int         beat_cnt = 0;
    int         stall_cnt = 0;
    exp_t       q[$];
    vec_t       vecs[8];

    axis_decimator_if #(.C_PIXEL_WIDTH(8)) s_if ();
    axis_decimator_if #(.C_PIXEL_WIDTH(8)) m_if ();

    axis_decimator #(.C_PIXEL_WIDTH(8), .C_STEP_BITS(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .h_step (h_step),
        .v_step (v_step),
        .s_axis (s_if),
        .m_axis (m_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard pop, hold-stability and stall counting, sampled mid-cycle.
    initial begin
        logic       hold = 1'b0;
        logic [9:0] held = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                hold = 1'b0;
            end else begin
                if (hold)
                    check("hold_stable", {m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast}, {1'b1, held});
                if (m_if.tvalid && m_if.tready) begin
                    beat_cnt++;
                    if (q.size() == 0) begin
                        compared++;
                        failed++;
                        $display("FAIL unexpected_beat: got %0h, expected no beat", m_if.tdata);
                    end else begin
                        e = q.pop_front();
                        check("beat", {m_if.tdata, m_if.tuser, m_if.tlast}, e);
                    end
                end
                hold = m_if.tvalid && !m_if.tready;
                held = {m_if.tdata, m_if.tuser, m_if.tlast};
                if (!s_if.tready)
                    stall_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_accept();
        logic a = 1'b0;
        int   t = 0;
        do begin
            @(negedge clk);
            a = s_if.tready;
            @(posedge clk);
            #1;
            t++;
        end while (!a && t < 1000);
        check("accept", 32'(a), 32'd1);
    endtask

    task automatic send_frame(input int w, input int h, input int hs, input int vs,
                              input int hs_mid, input int rnd, input int stop_after);
        int n = 0;
        int ehs = (hs == 0) ? 1 : hs;
        int evs = (vs == 0) ? 1 : vs;
        h_step = 4'(hs);
        v_step = 4'(vs);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (stop_after > 0 && n >= stop_after)
                    return;
                while (rnd != 0 && $urandom_range(1) == 0) begin
                    s_if.tvalid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                s_if.tvalid = 1'b1;
                s_if.tdata  = 8'(r * 16 + c);
                s_if.tuser  = (r == 0 && c == 0);
                s_if.tlast  = (c == w - 1);
                if (r % evs == 0 && c % ehs == 0)
                    q.push_back('{d: 8'(r * 16 + c), u: (r == 0 && c == 0), l: (c + ehs >= w)});
                wait_accept();
                n++;
                if (n == 1 && hs_mid >= 0)
                    h_step = 4'(hs_mid);
            end
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        //           w   h   hs vs mid rnd beats stalls
        vecs[0] = '{ 8,  6,  2, 3, -1, 0,   8,   0};
        vecs[1] = '{ 8,  6,  0, 1, -1, 0,  48,   6};
        vecs[2] = '{ 7,  4,  3, 1, -1, 0,  12,   4};
        vecs[3] = '{40, 30,  3, 2, -1, 1, 210,  -1};
        vecs[4] = '{40, 30,  3, 2, -1, 1, 210,  -1};
        vecs[5] = '{40, 30,  3, 2, -1, 1, 210,  -1};
        vecs[6] = '{12,  2,  5, 1,  2, 0,   6,   0};
        vecs[7] = '{12,  2,  2, 1, -1, 0,  12,   0};

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_tdata", 32'(m_if.tdata), 32'd0);
        check("rst_tuser_tlast", {m_if.tuser, m_if.tlast}, 32'd0);
        check("rst_tready", 32'(s_if.tready), 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            rnd_ready = (vecs[i].rnd != 0);
            beat_cnt  = 0;
            stall_cnt = 0;
            send_frame(vecs[i].w, vecs[i].h, vecs[i].hs, vecs[i].vs, vecs[i].hs_mid, vecs[i].rnd, 0);
            rnd_ready = 1'b0;
            drain();
            check($sformatf("beats_%0d", i), 32'(beat_cnt), 32'(vecs[i].beats));
            if (vecs[i].stalls >= 0)
                check($sformatf("stalls_%0d", i), 32'(stall_cnt), 32'(vecs[i].stalls));
        end

        // Reset mid-line with H holding col 2 and O holding col 0.
        send_frame(8, 6, 2, 1, -1, 0, 3);
        resetn = 1'b0;
        s_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_tvalid", 32'(m_if.tvalid), 32'd0);
        check("midrst_tready", 32'(s_if.tready), 32'd0);
        @(posedge clk);
        #1;
        q.delete();
        resetn = 1'b1;
        @(posedge clk);
        #1;
        beat_cnt = 0;
        send_frame(8, 6, 2, 3, -1, 0, 0);
        drain();
        check("post_rst_beats", 32'(beat_cnt), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
